// File: rtl/bcd_operand_entry.sv
// Keypad front end for the sign-magnitude BCD ALU: builds two-digit BCD operands
// from keypresses and drives the ALU load strobes, opcode and compute enable.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ENTER1 | typing the first operand
// ENTER2 | first operand loaded, typing the second operand
// RESULT | both operands loaded, ALU result valid (alu_en high)
module bcd_operand_entry #(
    parameter logic [2:0] ADD_OPCODE = 3'b001,
    parameter logic [2:0] SUB_OPCODE = 3'b010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [8:0] alu_result,
    output logic [8:0] op,
    output logic       assign_op1,
    output logic       assign_op2,
    output logic [2:0] opcode,
    output logic       alu_en,
    output logic [8:0] entry,
    output logic [1:0] state,
    output logic       key_err
);

    typedef enum logic [1:0] {
        ENTER1 = 2'd0,
        ENTER2 = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_EQ  = 4'd12;
    localparam logic [3:0] KEY_CLR = 4'd13;
    localparam logic [3:0] KEY_NEG = 4'd14;
    localparam logic [3:0] KEY_RSV = 4'd15;

    state_t     state_q, state_n;
    logic [1:0] count_q, count_n;
    logic [8:0] op_n, entry_n;
    logic [2:0] opcode_n;
    logic       assign_op1_n, assign_op2_n, alu_en_n, key_err_n;
    logic       is_digit, is_arith;
    logic [2:0] key_opcode;

    assign state      = state_q;
    assign is_digit   = (key_code < 4'd10);
    assign is_arith   = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    assign key_opcode = (key_code == KEY_SUB) ? SUB_OPCODE : ADD_OPCODE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENTER1;
            count_q    <= 2'd0;
            op         <= 9'd0;
            entry      <= 9'd0;
            opcode     <= 3'd0;
            assign_op1 <= 1'b0;
            assign_op2 <= 1'b0;
            alu_en     <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            state_q    <= state_n;
            count_q    <= count_n;
            op         <= op_n;
            entry      <= entry_n;
            opcode     <= opcode_n;
            assign_op1 <= assign_op1_n;
            assign_op2 <= assign_op2_n;
            alu_en     <= alu_en_n;
            key_err    <= key_err_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        count_n      = count_q;
        op_n         = op;
        entry_n      = entry;
        opcode_n     = opcode;
        assign_op1_n = 1'b0;
        assign_op2_n = 1'b0;
        alu_en_n     = alu_en;
        key_err_n    = 1'b0;

        // alu_en follows the op2 load by one cycle; a key this cycle may still clear it
        if (assign_op2) begin
            alu_en_n = 1'b1;
        end

        if (key_valid) begin
            if (key_code == KEY_CLR) begin
                state_n  = ENTER1;
                count_n  = 2'd0;
                entry_n  = 9'd0;
                opcode_n = 3'd0;
                alu_en_n = 1'b0;
            end else if (key_code == KEY_RSV) begin
                key_err_n = 1'b1;
            end else begin
                case (state_q)
                    ENTER1, ENTER2: begin
                        if (is_digit) begin
                            if (count_q < 2'd2) begin
                                entry_n = {entry[8], entry[3:0], key_code};
                                count_n = count_q + 2'd1;
                            end else begin
                                key_err_n = 1'b1;
                            end
                        end else if (key_code == KEY_NEG) begin
                            entry_n = {~entry[8], entry[7:0]};
                        end else if (is_arith) begin
                            opcode_n = key_opcode;
                            if (state_q == ENTER1) begin
                                op_n         = entry;
                                assign_op1_n = 1'b1;
                                entry_n      = 9'd0;
                                count_n      = 2'd0;
                                state_n      = ENTER2;
                            end
                        end else if (key_code == KEY_EQ) begin
                            if (state_q == ENTER2) begin
                                op_n         = entry;
                                assign_op2_n = 1'b1;
                                state_n      = RESULT;
                            end else begin
                                key_err_n = 1'b1;
                            end
                        end
                    end
                    RESULT: begin
                        if (is_digit) begin
                            alu_en_n = 1'b0;
                            entry_n  = {5'd0, key_code};
                            count_n  = 2'd1;
                            opcode_n = 3'd0;
                            state_n  = ENTER1;
                        end else if (is_arith) begin
                            // chain: the current result becomes the new first operand
                            op_n         = alu_result;
                            assign_op1_n = 1'b1;
                            opcode_n     = key_opcode;
                            alu_en_n     = 1'b0;
                            entry_n      = 9'd0;
                            count_n      = 2'd0;
                            state_n      = ENTER2;
                        end else begin
                            key_err_n = 1'b1;
                        end
                    end
                    default: begin
                        state_n = ENTER1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry: load strobes are checked against a
// scoreboard of expected operand loads; other outputs are checked inline.
module tb_bcd_operand_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [8:0] alu_result;
    logic [8:0] op;
    logic       assign_op1, assign_op2;
    logic [2:0] opcode;
    logic       alu_en;
    logic [8:0] entry;
    logic [1:0] state;
    logic       key_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       is_op2;
        logic [8:0] op;
        logic [2:0] opcode;
    } exp_t;
    exp_t sb[$];

    bcd_operand_entry dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_result(alu_result), .op(op), .assign_op1(assign_op1),
        .assign_op2(assign_op2), .opcode(opcode), .alu_en(alu_en),
        .entry(entry), .state(state), .key_err(key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic expect_load(input logic is_op2, input logic [8:0] v, input logic [2:0] oc);
        exp_t e;
        e.is_op2 = is_op2;
        e.op     = v;
        e.opcode = oc;
        sb.push_back(e);
    endtask

    // Strobe monitor: every load strobe must match the oldest expected load
    always @(negedge clk) begin
        if (assign_op1 || assign_op2) begin
            exp_t e;
            chk("strobe_exclusive", {8'd0, assign_op1 & assign_op2}, 9'd0);
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_strobe observed op1=%b op2=%b op=%h expected=no strobe",
                       assign_op1, assign_op2, op);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("strobe_kind", {8'd0, assign_op2}, {8'd0, e.is_op2});
                chk("strobe_op", op, e.op);
                chk("strobe_opcode", {6'd0, opcode}, {6'd0, e.opcode});
            end
        end
    end

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; alu_result = 9'd0;
        repeat (3) @(negedge clk);
        chk("rst_op", op, 9'd0);
        chk("rst_entry", entry, 9'd0);
        chk("rst_state", {7'd0, state}, 9'd0);
        chk("rst_ctrl", {3'd0, assign_op1, assign_op2, alu_en, key_err, opcode}, 9'd0);
        rst = 1'b0;

        // 45 + 12
        press(4); press(5);
        chk("entry_45", entry, 9'h045);
        expect_load(1'b0, 9'h045, 3'b001);
        press(10);
        chk("add_opcode", {6'd0, opcode}, 9'd1);
        chk("add_state", {7'd0, state}, 9'd1);
        chk("add_entry_clr", entry, 9'd0);
        press(1); press(2);
        expect_load(1'b1, 9'h012, 3'b001);
        press(12);
        chk("eq_state", {7'd0, state}, 9'd2);
        chk("eq_alu_en_early", {8'd0, alu_en}, 9'd0);
        @(negedge clk);
        chk("eq_alu_en", {8'd0, alu_en}, 9'd1);

        // chain: result 057 - 2
        alu_result = 9'h057;
        expect_load(1'b0, 9'h057, 3'b010);
        press(11);
        chk("chain_alu_en_drop", {8'd0, alu_en}, 9'd0);
        chk("chain_state", {7'd0, state}, 9'd1);
        press(2);
        expect_load(1'b1, 9'h002, 3'b010);
        press(12);
        @(negedge clk);
        chk("chain_alu_en", {8'd0, alu_en}, 9'd1);

        // new sequence from RESULT: -3 - 7
        press(3);
        chk("res_digit_state", {7'd0, state}, 9'd0);
        chk("res_digit_entry", entry, 9'h003);
        chk("res_digit_opc", {5'd0, alu_en, opcode}, 9'd0);
        press(14);
        chk("neg_entry", entry, 9'h103);
        expect_load(1'b0, 9'h103, 3'b010);
        press(11);
        press(7);
        expect_load(1'b1, 9'h007, 3'b010);
        press(12);
        @(negedge clk);
        chk("neg_alu_en", {8'd0, alu_en}, 9'd1);
        press(14);
        chk("res_neg_err", {8'd0, key_err}, 9'd1);
        chk("res_neg_entry", entry, 9'h007);
        press(12);
        chk("res_eq_err", {8'd0, key_err}, 9'd1);
        chk("res_eq_state", {7'd0, state}, 9'd2);
        press(13);
        chk("clr_res", {5'd0, alu_en, opcode}, 9'd0);
        chk("clr_res_state", {7'd0, state}, 9'd0);
        chk("op_hold", op, 9'h007);

        // digit overflow
        press(9); press(8);
        chk("entry_98", entry, 9'h098);
        press(7);
        chk("ovf_err", {8'd0, key_err}, 9'd1);
        chk("ovf_entry", entry, 9'h098);
        @(negedge clk);
        chk("err_one_cycle", {8'd0, key_err}, 9'd0);

        // rejected keys in ENTER1
        press(13);
        press(12);
        chk("e1_eq_err", {8'd0, key_err}, 9'd1);
        chk("e1_eq_state", {7'd0, state}, 9'd0);
        press(6);
        press(15);
        chk("rsv_err", {8'd0, key_err}, 9'd1);
        chk("rsv_entry", entry, 9'h006);

        // CLR in ENTER2
        press(13);
        press(1);
        expect_load(1'b0, 9'h001, 3'b001);
        press(10);
        press(2);
        press(13);
        chk("clr_e2_state", {7'd0, state}, 9'd0);
        chk("clr_e2_entry", entry, 9'd0);
        chk("clr_e2_opcode", {6'd0, opcode}, 9'd0);

        // operator replaced in ENTER2; zero-digit operand is legal
        expect_load(1'b0, 9'h000, 3'b001);
        press(10);
        press(11);
        chk("replace_opcode", {6'd0, opcode}, 9'd2);
        chk("replace_state", {7'd0, state}, 9'd1);

        // reset beats an EQ key in the same cycle
        press(5);
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b1; key_code = 4'd12;
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        chk("rst_eq_op2", {8'd0, assign_op2}, 9'd0);
        chk("rst_eq_state", {7'd0, state}, 9'd0);
        chk("rst_eq_entry", entry, 9'd0);
        chk("rst_eq_op", op, 9'd0);
        chk("rst_eq_ctrl", {5'd0, alu_en, opcode}, 9'd0);
        repeat (3) @(negedge clk);

        chk("sb_drained", sb.size(), 9'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
